// File: rtl/mem_ctrl_arbiter.sv
// Memory-side arbiter for the icache and dcache refill paths. It grants one request per cycle,
// keeps an in-order list of which cache owns each outstanding read, and routes each response back to that cache.
module mem_ctrl_arbiter #(
    parameter int  BLOCK_OFFSET_WIDTH = 3,
    parameter int  RQ_DEPTH           = 4,
    localparam int BW                 = 8 << BLOCK_OFFSET_WIDTH,
    localparam int AW                 = 32 - BLOCK_OFFSET_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_aL,
    input  logic                 icache_req_valid,
    input  logic [AW-1:0]        icache_req_block_addr,
    output logic                 icache_req_ready,
    output logic                 icache_resp_valid,
    output logic [BW-1:0]        icache_resp_block_data,
    input  logic                 dcache_req_valid,
    input  logic                 dcache_req_type,
    input  logic [31:0]          dcache_req_addr,
    input  logic [31:0]          dcache_req_wr_data,
    output logic                 dcache_req_ready,
    output logic                 dcache_resp_valid,
    output logic [BW-1:0]        dcache_resp_block_data,
    output logic                 mem_req_valid,
    output logic                 mem_req_we,
    output logic [AW-1:0]        mem_req_block_addr,
    output logic [BW-1:0]        mem_req_wr_data,
    output logic [BW/8-1:0]      mem_req_wmask,
    input  logic                 mem_resp_valid,
    input  logic [BW-1:0]        mem_resp_block_data,
    output logic                 protocol_err
);

    localparam int PW = $clog2(RQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = BLOCK_OFFSET_WIDTH - 2;
    localparam int MW = BW / 8;

    logic [CW-1:0]       count;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [RQ_DEPTH-1:0] src_fifo;     // 0 = icache, 1 = dcache
    logic                last_winner;  // 1 = dcache won the most recent conflict

    logic          fifo_full;
    logic          i_elig;
    logic          d_elig;
    logic          grant_i;
    logic          grant_d;
    logic          conflict;
    logic          push;
    logic          pop;
    logic          head_src;
    logic [LW-1:0] lane;
    logic [BW-1:0] wr_data_lane;
    logic [MW-1:0] wmask_lane;
    logic          unused_addr_bits;

    assign unused_addr_bits = &{1'b0, dcache_req_addr[1:0]};

    always_comb begin
        fifo_full    = (count == CW'(RQ_DEPTH));
        i_elig       = icache_req_valid && !fifo_full;
        d_elig       = dcache_req_valid && (dcache_req_type || !fifo_full);
        conflict     = i_elig && d_elig;
        grant_d      = d_elig && (!i_elig || !last_winner);
        grant_i      = i_elig && (!d_elig || last_winner);
        push         = grant_i || (grant_d && !dcache_req_type);
        pop          = mem_resp_valid && (count != '0);
        head_src     = src_fifo[rd_ptr];
        lane         = dcache_req_addr[BLOCK_OFFSET_WIDTH-1:2];
        wr_data_lane = BW'(dcache_req_wr_data) << (32 * int'(lane));
        wmask_lane   = MW'(4'hF) << (4 * int'(lane));
    end

    // Readies are forced low while reset is held so nothing is handshaken during reset.
    assign icache_req_ready = rst_aL && grant_i;
    assign dcache_req_ready = rst_aL && grant_d;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            mem_req_valid      <= 1'b0;
            mem_req_we         <= 1'b0;
            mem_req_block_addr <= '0;
            mem_req_wr_data    <= '0;
            mem_req_wmask      <= '0;
        end else begin
            mem_req_valid <= grant_i || grant_d;
            if (grant_i) begin
                mem_req_we         <= 1'b0;
                mem_req_block_addr <= icache_req_block_addr;
                mem_req_wr_data    <= '0;
                mem_req_wmask      <= '0;
            end else if (grant_d) begin
                mem_req_we         <= dcache_req_type;
                mem_req_block_addr <= dcache_req_addr[31:BLOCK_OFFSET_WIDTH];
                mem_req_wr_data    <= dcache_req_type ? wr_data_lane : '0;
                mem_req_wmask      <= dcache_req_type ? wmask_lane : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            src_fifo    <= '0;
            last_winner <= 1'b0;
        end else begin
            if (push) begin
                src_fifo[wr_ptr] <= grant_d;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (conflict)
                last_winner <= grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            icache_resp_valid      <= 1'b0;
            dcache_resp_valid      <= 1'b0;
            icache_resp_block_data <= '0;
            dcache_resp_block_data <= '0;
            protocol_err           <= 1'b0;
        end else begin
            icache_resp_valid <= pop && !head_src;
            dcache_resp_valid <= pop && head_src;
            if (pop && !head_src)
                icache_resp_block_data <= mem_resp_block_data;
            if (pop && head_src)
                dcache_resp_block_data <= mem_resp_block_data;
            if (mem_resp_valid && (count == '0))
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Bench for mem_ctrl_arbiter: directed and random traffic checked against a queue-based model
// of arbitration fairness, write-lane expansion and in-order response routing.
module tb_mem_ctrl_arbiter;
    localparam int BOW = 3;
    localparam int RQD = 4;
    localparam int BW  = 64;
    localparam int AW  = 29;
    localparam int MW  = 8;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          iv;
    logic [AW-1:0] ia;
    logic          icache_req_ready;
    logic          icache_resp_valid;
    logic [BW-1:0] icache_resp_block_data;
    logic          dv;
    logic          dt;
    logic [31:0]   da;
    logic [31:0]   dw;
    logic          dcache_req_ready;
    logic          dcache_resp_valid;
    logic [BW-1:0] dcache_resp_block_data;
    logic          mem_req_valid;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_block_addr;
    logic [BW-1:0] mem_req_wr_data;
    logic [MW-1:0] mem_req_wmask;
    logic          rv;
    logic [BW-1:0] rd;
    logic          protocol_err;

    always #5 clk = ~clk;

    mem_ctrl_arbiter #(.BLOCK_OFFSET_WIDTH(BOW), .RQ_DEPTH(RQD)) dut (
        .clk                    (clk),
        .rst_aL                 (rst_aL),
        .icache_req_valid       (iv),
        .icache_req_block_addr  (ia),
        .icache_req_ready       (icache_req_ready),
        .icache_resp_valid      (icache_resp_valid),
        .icache_resp_block_data (icache_resp_block_data),
        .dcache_req_valid       (dv),
        .dcache_req_type        (dt),
        .dcache_req_addr        (da),
        .dcache_req_wr_data     (dw),
        .dcache_req_ready       (dcache_req_ready),
        .dcache_resp_valid      (dcache_resp_valid),
        .dcache_resp_block_data (dcache_resp_block_data),
        .mem_req_valid          (mem_req_valid),
        .mem_req_we             (mem_req_we),
        .mem_req_block_addr     (mem_req_block_addr),
        .mem_req_wr_data        (mem_req_wr_data),
        .mem_req_wmask          (mem_req_wmask),
        .mem_resp_valid         (rv),
        .mem_resp_block_data    (rd),
        .protocol_err           (protocol_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of owners of outstanding reads, who won the last conflict, sticky error.
    int q[$];
    int prev_win;
    bit exp_perr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        iv = 1'b0; ia = '0; dv = 1'b0; dt = 1'b0; da = '0; dw = '0; rv = 1'b0; rd = '0;
    endtask

    // Entered just after a rising edge with inputs already driven; returns just after the next edge.
    task automatic cycle();
        int win;
        int lane;
        int src;
        bit full, ie, de, has_src, e_we;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_data;
        logic [MW-1:0] e_mask;
        logic [BW-1:0] r_data;
        #1;
        full = (q.size() >= RQD);
        ie = iv && !full;
        de = dv && (dt || !full);
        if (ie && de) begin
            win = (prev_win == 0) ? 1 : 0;
            prev_win = win;
        end else if (ie) win = 0;
        else if (de) win = 1;
        else win = -1;
        chk("icache_ready", icache_req_ready, 64'(win == 0));
        chk("dcache_ready", dcache_req_ready, 64'(win == 1));
        e_we = 1'b0; e_addr = '0; e_data = '0; e_mask = '0;
        if (win == 0) begin
            e_addr = ia;
        end else if (win == 1) begin
            e_addr = da >> BOW;
            if (dt) begin
                lane   = (da >> 2) % (1 << (BOW - 2));
                e_we   = 1'b1;
                e_data = BW'(dw) << (32 * lane);
                e_mask = MW'(8'h0F) << (4 * lane);
            end
        end
        has_src = 1'b0;
        src = 0;
        r_data = rd;
        if (rv) begin
            if (q.size() > 0) begin
                src = q.pop_front();
                has_src = 1'b1;
            end else begin
                exp_perr = 1'b1;
            end
        end
        if (win == 0) q.push_back(0);
        else if (win == 1 && !dt) q.push_back(1);
        @(posedge clk);
        #1;
        chk("mem_req_valid", mem_req_valid, 64'(win >= 0));
        if (win >= 0) begin
            chk("mem_req_we", mem_req_we, 64'(e_we));
            chk("mem_req_addr", mem_req_block_addr, e_addr);
            chk("mem_req_wmask", mem_req_wmask, e_mask);
            if (e_we) chk("mem_req_wr_data", mem_req_wr_data, e_data);
        end
        chk("icache_resp_valid", icache_resp_valid, 64'(has_src && src == 0));
        chk("dcache_resp_valid", dcache_resp_valid, 64'(has_src && src == 1));
        if (has_src && src == 0) chk("icache_resp_data", icache_resp_block_data, r_data);
        if (has_src && src == 1) chk("dcache_resp_data", dcache_resp_block_data, r_data);
        chk("protocol_err", protocol_err, 64'(exp_perr));
    endtask

    // Asserts reset between edges with both caches requesting; outputs must clear at once.
    task automatic reset_check(input string tag);
        rst_aL = 1'b0;
        iv = 1'b1; ia = 29'h155; dv = 1'b1; dt = 1'b0; da = 32'h400;
        #1;
        chk({tag, "_icache_ready"}, icache_req_ready, 0);
        chk({tag, "_dcache_ready"}, dcache_req_ready, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_req_addr"}, mem_req_block_addr, 0);
        chk({tag, "_mem_req_wmask"}, mem_req_wmask, 0);
        chk({tag, "_mem_req_data"}, mem_req_wr_data, 0);
        chk({tag, "_icache_resp_valid"}, icache_resp_valid, 0);
        chk({tag, "_dcache_resp_valid"}, dcache_resp_valid, 0);
        chk({tag, "_protocol_err"}, protocol_err, 0);
        q.delete();
        prev_win = 0;
        exp_perr = 1'b0;
        set_idle();
        @(posedge clk);
        #2;
        rst_aL = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst_aL = 1'b1;
        prev_win = 0;
        exp_perr = 1'b0;
        #2;
        reset_check("init");

        // Single icache read and its response.
        iv = 1'b1; ia = 29'h2030;
        cycle();
        chk("tp1_addr", mem_req_block_addr, 29'h2030);
        set_idle();
        rv = 1'b1; rd = 64'h1122334455667788;
        cycle();
        chk("tp1_icache_data", icache_resp_block_data, 64'h1122334455667788);
        set_idle();
        cycle();

        // dcache word write into the upper lane.
        dv = 1'b1; dt = 1'b1; da = 32'h0001018c; dw = 32'hDEADBEEF;
        cycle();
        chk("tp2_addr", mem_req_block_addr, 29'h2031);
        chk("tp2_wmask", mem_req_wmask, 8'hF0);
        chk("tp2_data", mem_req_wr_data, 64'hDEADBEEF_00000000);
        set_idle();
        cycle();

        // Two consecutive conflicts: dcache first, then icache.
        iv = 1'b1; ia = 29'h0A0; dv = 1'b1; dt = 1'b0; da = 32'h0000_0B00;
        cycle();
        cycle();
        set_idle();
        rv = 1'b1; rd = 64'hAAAA_0000_0000_0001;
        cycle();
        rd = 64'hBBBB_0000_0000_0002;
        cycle();
        set_idle();
        cycle();

        // Fill the routing FIFO, then check full-FIFO behaviour.
        for (int i = 0; i < RQD; i++) begin
            iv = 1'b1; ia = AW'(29'h300 + i);
            cycle();
        end
        iv = 1'b1; ia = 29'h3FF; dv = 1'b1; dt = 1'b1; da = 32'h0000_2004; dw = 32'h12345678;
        cycle();
        dt = 1'b0;
        cycle();
        dv = 1'b0; rv = 1'b1; rd = 64'hC0C0_C0C0_0000_0000;
        cycle();
        rv = 1'b0;
        cycle();
        cycle();
        set_idle();
        while (q.size() > 0) begin
            rv = 1'b1; rd = {$urandom, $urandom};
            cycle();
        end
        set_idle();

        // Alternating reads with responses interleaved (pointer wrap, push+pop together).
        for (int i = 0; i < 10; i++) begin
            iv = (i % 2 == 0); ia = AW'($urandom);
            dv = (i % 2 == 1); dt = 1'b0; da = $urandom;
            rv = (q.size() > 0); rd = {$urandom, $urandom};
            cycle();
        end
        set_idle();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            iv = 1'($urandom_range(0, 1)); ia = AW'($urandom);
            dv = 1'($urandom_range(0, 1)); dt = 1'($urandom_range(0, 2) == 0);
            da = $urandom; dw = $urandom;
            rv = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            rd = {$urandom, $urandom};
            cycle();
        end
        set_idle();
        while (q.size() > 0) begin
            rv = 1'b1; rd = {$urandom, $urandom};
            cycle();
        end
        set_idle();
        cycle();

        // Reset with three reads outstanding, then a stale response.
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1; ia = AW'(29'h500 + i);
            cycle();
        end
        set_idle();
        reset_check("midrst");
        rv = 1'b1; rd = 64'hDEAD_0000_BEEF_0000;
        cycle();
        chk("stale_perr", protocol_err, 1);
        set_idle();
        cycle();
        iv = 1'b1; ia = 29'h777; dv = 1'b1; dt = 1'b0; da = 32'h0000_8000;
        cycle();
        set_idle();
        cycle();
        chk("perr_sticky", protocol_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl_arbiter.md
# mem_ctrl_arbiter

Memory controller between the core's two L1 caches (icache refill, dcache refill/write-through) and the main memory model. It arbitrates one request per cycle onto a single non-backpressured memory request port, tracks outstanding block reads in an in-order routing FIFO, and returns each memory response to the cache that issued the read. Dcache word writes are expanded into a byte-masked block write.

## Interface
- BLOCK_OFFSET_WIDTH, 3, log2 block bytes; block data width BW = 8<<BLOCK_OFFSET_WIDTH (default 64 bits), block addr width AW = 32-BLOCK_OFFSET_WIDTH
- RQ_DEPTH, 4, max outstanding reads; power of two, >=2
- clk  in  1  clock; all state on rising edge
- rst_aL  in  1  asynchronous, active-low reset
- icache_req_valid  in  1  icache block read request
- icache_req_block_addr  in  AW  block address
- icache_req_ready  out  1  grant; handshake completes when valid&ready
- icache_resp_valid  out  1  one-cycle pulse, data valid
- icache_resp_block_data  out  BW  returned block
- dcache_req_valid  in  1  dcache request
- dcache_req_type  in  1  0=READ (block), 1=WRITE (word)
- dcache_req_addr  in  32  byte address; READ uses bits [31:BLOCK_OFFSET_WIDTH], WRITE uses [31:2]
- dcache_req_wr_data  in  32  write word
- dcache_req_ready  out  1  grant
- dcache_resp_valid  out  1  one-cycle pulse, read data valid
- dcache_resp_block_data  out  BW  returned block
- mem_req_valid  out  1  memory request (memory always accepts)
- mem_req_we  out  1  1=write
- mem_req_block_addr  out  AW  block address
- mem_req_wr_data  out  BW  write data, word placed at its lane
- mem_req_wmask  out  BW/8  byte enables; all-zero for reads
- mem_resp_valid  in  1  read response, in request order
- mem_resp_block_data  in  BW  response data
- protocol_err  out  1  sticky; response with no outstanding read

## Operation
- Grant is combinational from valids, last_winner, count: READ needs count<RQ_DEPTH (no same-cycle pop bypass); dcache WRITE needs no FIFO space.
- One valid eligible source -> granted. Both eligible -> source that did not win last conflict; last_winner updates only on conflicts; after reset dcache wins first conflict.
- Ineligible source (FIFO full, READ) is not granted; other source may be.
- Accepted READ: push source id (0=icache,1=dcache) to routing FIFO; count++.
- Accepted WRITE: word lane = addr[BLOCK_OFFSET_WIDTH-1:2]; wr_data shifted to lane*32, wmask = 4'hF << lane*4; addr[1:0] ignored; nothing pushed.
- mem_resp_valid: pop FIFO head, route data to that source; count--. Push+pop same cycle: count unchanged, both pointers advance.
- mem_resp_valid with count==0: no pop, no resp pulse, protocol_err set until reset.
- Pointers wrap modulo RQ_DEPTH; count is clog2(RQ_DEPTH)+1 bits, range 0..RQ_DEPTH.

## Timing
- Reset (async assert, immediate): all *_valid, protocol_err, count, pointers = 0; mem_req data/addr/mask = 0; last_winner = icache (dcache wins next conflict). Ready outputs are 0 while rst_aL low, otherwise per grant logic.
- Request accepted at edge E -> mem_req_* registered, valid for the one cycle after E. Back-to-back acceptance gives back-to-back mem_req_valid.
- mem_resp_valid sampled at edge R -> *_resp_valid + data registered, high for the cycle after R (1-cycle routing latency).
- Ready reflects count at start of cycle; a pop at edge R reopens READ grants in the cycle after R.
- Reset mid-flight drops all outstanding reads; later stale responses raise protocol_err.

## Test plan
- icache READ block 0x2030 -> mem_req_valid=1, we=0, block_addr=0x2030, wmask=0 next cycle; mem_resp 0x1122334455667788 -> icache_resp_valid pulse with that data one cycle later; dcache_resp_valid stays 0.
- dcache WRITE addr 0x1018c data 0xDEADBEEF -> block_addr 0x2031, wmask 8'hF0, wr_data 0xDEADBEEF_00000000; no FIFO push.
- Both READ valid two consecutive conflicts -> first grant dcache, second icache; responses routed in that order.
- 4 READs with no responses -> both READ readies 0, 5th held; dcache WRITE still granted; one mem_resp -> READ granted next cycle, count back to 4.
- 10 alternating READs with responses interleaved so pointers wrap twice -> every response reaches the correct cache in order; same-cycle push+pop keeps count.
- Assert rst_aL low with 3 reads outstanding -> outputs zero immediately; after release a mem_resp_valid -> no resp pulse, protocol_err=1 and stays 1.
